// File: rtl/nnet_vector_length_fixer_if.sv
// nnet_vector_length_fixer_if: AXI-stream sample bus carrying 2*WIDTH-bit I/Q words.
interface nnet_vector_length_fixer_if #(parameter int WIDTH = 16);
  logic [2*WIDTH-1:0] tdata;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master (output tdata, tlast, tvalid, input tready);
  modport slave (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/nnet_vector_length_fixer.sv
// nnet_vector_length_fixer: pads short / truncates long vectors to exactly vec_len samples.
// Define NNET_VLF_STATUS_EN to get live short_cnt/long_cnt saturating counters.
module nnet_vector_length_fixer #(
  parameter int WIDTH = 16,
  parameter logic [2*WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic [15:0] vec_len,
  nnet_vector_length_fixer_if.slave src,
  nnet_vector_length_fixer_if.master dst,
  output logic [15:0] short_cnt,
  output logic [15:0] long_cnt
);
  typedef enum logic [1:0] {PASS, PAD, DROP} state_t;
  state_t state;
  logic [15:0] cnt, len_q, len_in, eff_len;
  logic last, beat, short_ev, long_ev;
  assign len_in = (vec_len == 16'd0) ? 16'd1 : vec_len;
  assign eff_len = (cnt == 16'd0) ? len_in : len_q;
  assign last = (cnt == eff_len - 16'd1);
  assign beat = (state == PASS) && src.tvalid && dst.tready;
  assign short_ev = beat && !last && src.tlast;
  assign long_ev = beat && last && !src.tlast;
  // Data path is purely combinational in PASS; only PAD substitutes the word.
  assign dst.tdata = (state == PAD) ? PAD_VALUE : src.tdata;
  assign dst.tvalid = (state == PASS) ? src.tvalid : (state == PAD);
  assign dst.tlast = (state != DROP) && last;
  assign src.tready = (state == PASS) ? dst.tready : (state == DROP);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= PASS;
      cnt <= '0;
      len_q <= 16'd1;
    end else if (clear) begin
      state <= PASS;
      cnt <= '0;
      len_q <= 16'd1;
    end else begin
      case (state)
        PASS: if (beat) begin
          if (cnt == 16'd0) len_q <= len_in;
          cnt <= last ? 16'd0 : cnt + 16'd1;
          if (long_ev) state <= DROP;
          if (short_ev) state <= PAD;
        end
        PAD: if (dst.tready) begin
          cnt <= last ? 16'd0 : cnt + 16'd1;
          if (last) state <= PASS;
        end
        DROP: if (src.tvalid && src.tlast) state <= PASS;
        default: state <= PASS;
      endcase
    end
  end
`ifdef NNET_VLF_STATUS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      short_cnt <= '0;
      long_cnt <= '0;
    end else if (clear) begin
      short_cnt <= '0;
      long_cnt <= '0;
    end else begin
      if (short_ev && short_cnt != 16'hFFFF) short_cnt <= short_cnt + 16'd1;
      if (long_ev && long_cnt != 16'hFFFF) long_cnt <= long_cnt + 16'd1;
    end
  end
`else
  assign short_cnt = '0;
  assign long_cnt = '0;
`endif
endmodule

// File: tb/tb_nnet_vector_length_fixer.sv
// tb_nnet_vector_length_fixer: scoreboard bench with a vector-level reference model.
module tb_nnet_vector_length_fixer;
  localparam logic [31:0] PADV = 32'hDEAD_BEEF;
`ifdef NNET_VLF_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif
  logic clk = 0, reset_n = 0, clear = 0;
  logic [15:0] vec_len = 16'd0;
  logic [15:0] short_cnt, long_cnt;
  int checks = 0, errors = 0;
  int exp_short = 0, exp_long = 0;
  int rdy_mode = 0;
  bit mon_en = 0;
  logic [32:0] q[$];
  nnet_vector_length_fixer_if #(.WIDTH(16)) src();
  nnet_vector_length_fixer_if #(.WIDTH(16)) dst();
  nnet_vector_length_fixer #(.WIDTH(16), .PAD_VALUE(PADV)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .vec_len(vec_len),
    .src(src), .dst(dst), .short_cnt(short_cnt), .long_cnt(long_cnt)
  );
  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    dst.tready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  bit prev_stall = 0;
  logic [31:0] prev_data;
  logic prev_last;
  always @(negedge clk) begin
    if (!mon_en) prev_stall <= 0;
    else if (dst.tvalid) begin
      if (prev_stall) begin
        chk("stall_data", dst.tdata, prev_data);
        chk("stall_last", dst.tlast, prev_last);
      end
      if (dst.tready) begin
        if (q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          logic [32:0] e;
          e = q.pop_front();
          chk("out_data", dst.tdata, e[32:1]);
          chk("out_last", dst.tlast, e[0]);
        end
        prev_stall <= 0;
      end else begin
        prev_stall <= 1;
        prev_data <= dst.tdata;
        prev_last <= dst.tlast;
      end
    end else prev_stall <= 0;
  end

  task automatic beat(logic [31:0] d, logic l);
    bit acc;
    int n = 0;
    src.tvalid = 1;
    src.tdata = d;
    src.tlast = l;
    do begin
      @(negedge clk);
      acc = src.tready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) chk("beat_timeout", 0, 1);
    src.tvalid = 0;
  endtask

  task automatic send_vec(int n, int chg_idx = -1, logic [15:0] nl = 16'd0);
    int L = (vec_len == 0) ? 1 : int'(vec_len);
    logic [31:0] d[$];
    for (int i = 0; i < n; i++) begin
      d.push_back($urandom);
      if (i < L) q.push_back({d[i], i == L - 1});
    end
    for (int i = n; i < L; i++) q.push_back({PADV, i == L - 1});
    if (n < L) exp_short++;
    if (n > L) exp_long++;
    for (int i = 0; i < n; i++) begin
      if (i == chg_idx) vec_len = nl;
      if (rdy_mode == 2 && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      beat(d[i], i == n - 1);
    end
  endtask

  task automatic drain_and_count(string tag);
    int n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_drain"}, q.size(), 0);
    @(posedge clk);
    #1;
    chk({tag, "_short_cnt"}, short_cnt, STAT ? exp_short : 0);
    chk({tag, "_long_cnt"}, long_cnt, STAT ? exp_long : 0);
  endtask

  initial begin
    src.tvalid = 1;
    src.tdata = 32'h1234_5678;
    src.tlast = 0;
    dst.tready = 0;
    #3;
    chk("rst_valid_pass", dst.tvalid, 1);
    chk("rst_ready_pass", src.tready, 0);
    chk("rst_tlast_len0", dst.tlast, 1);
    chk("rst_data_pass", dst.tdata, 32'h1234_5678);
    chk("rst_short", short_cnt, 0);
    chk("rst_long", long_cnt, 0);
    src.tvalid = 0;
    vec_len = 16'd4;
    #1;
    chk("rst_tlast_len4", dst.tlast, 0);
    @(posedge clk);
    #2;
    reset_n = 1;
    rdy_mode = 1;
    @(posedge clk);
    #1;
    mon_en = 1;
    send_vec(4);
    drain_and_count("exact");
    send_vec(2);
    drain_and_count("short");
    vec_len = 16'd3;
    send_vec(5);
    drain_and_count("long");
    vec_len = 16'd4;
    rdy_mode = 2;
    for (int v = 0; v < 100; v++) send_vec($urandom_range(1, 7));
    drain_and_count("random");
    rdy_mode = 1;
    send_vec(4, 1, 16'd2);
    send_vec(2);
    send_vec(3);
    drain_and_count("len_change");
    vec_len = 16'd0;
    send_vec(1);
    send_vec(1);
    send_vec(3);
    send_vec(1);
    drain_and_count("len_zero");
    // Async reset while padding: monitor is off because the pad beat is aborted.
    vec_len = 16'd4;
    mon_en = 0;
    beat(32'hA, 0);
    beat(32'hB, 1);
    chk("pad_valid", dst.tvalid, 1);
    chk("pad_data", dst.tdata, PADV);
    chk("pad_ready", src.tready, 0);
    #1 reset_n = 0;
    #1;
    chk("arst_valid", dst.tvalid, 0);
    chk("arst_ready", src.tready, 1);
    chk("arst_tlast", dst.tlast, 0);
    chk("arst_short", short_cnt, 0);
    chk("arst_long", long_cnt, 0);
    #2 reset_n = 1;
    @(posedge clk);
    #1;
    q.delete();
    exp_short = 0;
    exp_long = 0;
    mon_en = 1;
    send_vec(4);
    drain_and_count("after_arst");
    vec_len = 16'd2;
    q.push_back({32'hC, 1'b0});
    q.push_back({32'hD, 1'b1});
    beat(32'hC, 0);
    beat(32'hD, 0);
    exp_long++;
    drain_and_count("into_drop");
    rdy_mode = 0;
    @(posedge clk);
    #1;
    chk("drop_ready", src.tready, 1);
    clear = 1;
    @(posedge clk);
    #1;
    clear = 0;
    chk("clear_ready", src.tready, 0);
    chk("clear_long", long_cnt, 0);
    exp_short = 0;
    exp_long = 0;
    rdy_mode = 1;
    @(posedge clk);
    #1;
    send_vec(2);
    send_vec(1);
    drain_and_count("after_clear");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
